// File: rtl/pll_seq_pkg.sv
// PLL reconfiguration sequencer: shared types, widths and source decode.
// Imported by the interface, timer and sequencer top.
package pll_seq_pkg;

    localparam int N_CH = 4;
    localparam int DIV_W = 4;
    localparam int SEL_W = 2;
    localparam logic [SEL_W-1:0] SEL_CLK = '0;
    localparam int ST_W = 3;
    localparam int TMR_W = 8;

    typedef enum logic [ST_W-1:0] {
        ST_IDLE,
        ST_REJECT,
        ST_QUIESCE,
        ST_LOAD,
        ST_LOCK_C,
        ST_LOCK_DEP,
        ST_DONE
    } state_t;

    typedef struct packed {
        logic       vld;
        logic [1:0] ch;
    } src_t;

    // Select k>0 picks the k-th other channel in ascending order, so a
    // channel can never name itself; vld=0 means the reference clock.
    function automatic src_t src_of(input logic [1:0] ch,
                                    input logic [SEL_W-1:0] sel);
        src_t       r;
        logic [1:0] km1;
        km1   = sel - 2'd1;
        r.vld = (sel != SEL_CLK);
        r.ch  = '0;
        if (r.vld) begin
            r.ch = (km1 < ch) ? km1 : sel;
        end
        return r;
    endfunction

endpackage

// File: rtl/pll_reconfig_seq_if.sv
// Request handshake between the CSR front end and the sequencer.
// One atomic channel reconfiguration per accepted transfer.
interface pll_reconfig_seq_if;
    import pll_seq_pkg::*;

    logic             req_valid;
    logic             req_ready;
    logic [1:0]       req_ch;
    logic [DIV_W-1:0] req_div_fb;
    logic [DIV_W-1:0] req_div_out;
    logic [SEL_W-1:0] req_sel;

    modport master (
        output req_valid,
        output req_ch,
        output req_div_fb,
        output req_div_out,
        output req_sel,
        input  req_ready
    );

    modport slave (
        input  req_valid,
        input  req_ch,
        input  req_div_fb,
        input  req_div_out,
        input  req_sel,
        output req_ready
    );

endinterface

// File: rtl/pll_seq_timer.sv
// Loadable down-counter shared by the power-down and lock-wait states.
// expire is high in the last cycle of a loaded interval.
module pll_seq_timer
    import pll_seq_pkg::*;
(
    input  logic             clk_csr,
    input  logic             rst_n,
    input  logic             load,
    input  logic [TMR_W-1:0] load_val,
    output logic             expire
);

    logic [TMR_W-1:0] count_q;
    logic [TMR_W-1:0] count_d;

    // Load wins; otherwise count down and park at zero.
    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_val;
        end else if (count_q != '0) begin
            count_d = count_q - 1'b1;
        end
    end

    // Counter register.
    always_ff @(posedge clk_csr or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expire = (count_q == TMR_W'(1));

endmodule

// File: rtl/pll_reconfig_seq.sv
// Glitch-safe PLL channel reconfiguration sequencer: quiesce target and
// its enabled dependents, load dividers/select, re-enable in lock order.
module pll_reconfig_seq
    import pll_seq_pkg::*;
#(
    parameter int unsigned OFF_CYC  = 8,
    parameter int unsigned LOCK_CYC = 64
) (
    input  logic                   clk_csr,
    input  logic                   rst_n,
    pll_reconfig_seq_if.slave      req,
    output logic [N_CH*DIV_W-1:0]  div_fb_o,
    output logic [N_CH*DIV_W-1:0]  div_out_o,
    output logic [N_CH*SEL_W-1:0]  clk_sel_o,
    output logic [N_CH-1:0]        enb_o,
    output logic                   busy,
    output logic                   done_pulse,
    output logic                   err_pulse
);

    localparam logic [N_CH*DIV_W-1:0] DIV_RST = {N_CH{DIV_W'(1)}};

    state_t                  state_q, state_d;
    logic [1:0]              ch_q, ch_d;
    logic [DIV_W-1:0]        fb_q, fb_d;
    logic [DIV_W-1:0]        out_q, out_d;
    logic [SEL_W-1:0]        sel_q, sel_d;
    logic [N_CH-1:0]         dep_q, dep_d;
    logic [N_CH-1:0]         enb_q, enb_d;
    logic [N_CH*DIV_W-1:0]   div_fb_q, div_fb_d;
    logic [N_CH*DIV_W-1:0]   div_out_q, div_out_d;
    logic [N_CH*SEL_W-1:0]   clk_sel_q, clk_sel_d;
    logic                    done_q, done_d;
    logic                    err_q, err_d;

    logic                    tmr_load;
    logic [TMR_W-1:0]        tmr_val;
    logic                    tmr_exp;

    src_t                    cur_src [N_CH];
    src_t                    req_src;
    logic [N_CH-1:0]         dep;
    logic                    loop_bad;
    logic                    bad;
    logic                    accept;

    pll_seq_timer u_timer (
        .clk_csr  (clk_csr),
        .rst_n    (rst_n),
        .load     (tmr_load),
        .load_val (tmr_val),
        .expire   (tmr_exp)
    );

    // Decode every channel's current source and the request's dependents.
    always_comb begin
        dep = '0;
        for (int j = 0; j < N_CH; j++) begin
            cur_src[j] = src_of(2'(j), clk_sel_q[j*SEL_W +: SEL_W]);
            dep[j] = (2'(j) != req.req_ch) && !enb_q[j] &&
                     cur_src[j].vld && (cur_src[j].ch == req.req_ch);
        end
        req_src  = src_of(req.req_ch, req.req_sel);
        loop_bad = req_src.vld && cur_src[req_src.ch].vld &&
                   (cur_src[req_src.ch].ch == req.req_ch);
        bad      = (req.req_div_fb == '0) || (req.req_div_out == '0) ||
                   loop_bad;
    end

    assign accept = req.req_valid && (state_q == ST_IDLE);

    // Sequencer next-state and output-register updates.
    always_comb begin
        state_d   = state_q;
        ch_d      = ch_q;
        fb_d      = fb_q;
        out_d     = out_q;
        sel_d     = sel_q;
        dep_d     = dep_q;
        enb_d     = enb_q;
        div_fb_d  = div_fb_q;
        div_out_d = div_out_q;
        clk_sel_d = clk_sel_q;
        done_d    = 1'b0;
        err_d     = 1'b0;
        tmr_load  = 1'b0;
        tmr_val   = '0;
        unique case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (bad) begin
                        err_d   = 1'b1;
                        state_d = ST_REJECT;
                    end else begin
                        ch_d     = req.req_ch;
                        fb_d     = req.req_div_fb;
                        out_d    = req.req_div_out;
                        sel_d    = req.req_sel;
                        dep_d    = dep;
                        enb_d    = enb_q | dep |
                                   (N_CH'(1) << req.req_ch);
                        tmr_load = 1'b1;
                        tmr_val  = TMR_W'(OFF_CYC);
                        state_d  = ST_QUIESCE;
                    end
                end
            end
            ST_REJECT: begin
                state_d = ST_IDLE;
            end
            ST_QUIESCE: begin
                if (tmr_exp) begin
                    div_fb_d[{ch_q, 2'b00} +: DIV_W]  = fb_q;
                    div_out_d[{ch_q, 2'b00} +: DIV_W] = out_q;
                    clk_sel_d[{ch_q, 1'b0} +: SEL_W]  = sel_q;
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                enb_d[ch_q] = 1'b0;
                tmr_load    = 1'b1;
                tmr_val     = TMR_W'(LOCK_CYC);
                state_d     = ST_LOCK_C;
            end
            ST_LOCK_C: begin
                if (tmr_exp) begin
                    if (dep_q == '0) begin
                        done_d  = 1'b1;
                        state_d = ST_DONE;
                    end else begin
                        enb_d    = enb_q & ~dep_q;
                        tmr_load = 1'b1;
                        tmr_val  = TMR_W'(LOCK_CYC);
                        state_d  = ST_LOCK_DEP;
                    end
                end
            end
            ST_LOCK_DEP: begin
                if (tmr_exp) begin
                    done_d  = 1'b1;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, captured request and output registers.
    always_ff @(posedge clk_csr or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            ch_q      <= '0;
            fb_q      <= '0;
            out_q     <= '0;
            sel_q     <= '0;
            dep_q     <= '0;
            enb_q     <= '1;
            div_fb_q  <= DIV_RST;
            div_out_q <= DIV_RST;
            clk_sel_q <= '0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            ch_q      <= ch_d;
            fb_q      <= fb_d;
            out_q     <= out_d;
            sel_q     <= sel_d;
            dep_q     <= dep_d;
            enb_q     <= enb_d;
            div_fb_q  <= div_fb_d;
            div_out_q <= div_out_d;
            clk_sel_q <= clk_sel_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end

    assign req.req_ready = (state_q == ST_IDLE);
    assign busy          = (state_q != ST_IDLE);
    assign div_fb_o      = div_fb_q;
    assign div_out_o     = div_out_q;
    assign clk_sel_o     = clk_sel_q;
    assign enb_o         = enb_q;
    assign done_pulse    = done_q;
    assign err_pulse     = err_q;

endmodule

// File: tb/tb_pll_reconfig_seq.sv
// Directed bench for pll_reconfig_seq with OFF_CYC=2, LOCK_CYC=4.
// Cycle k = k rising edges after the accept edge's predecessor.
module tb_pll_reconfig_seq;

    logic        clk_csr;
    logic        rst_n;
    logic [15:0] div_fb_o;
    logic [15:0] div_out_o;
    logic [7:0]  clk_sel_o;
    logic [3:0]  enb_o;
    logic        busy;
    logic        done_pulse;
    logic        err_pulse;

    int n_chk;
    int n_err;
    int lat;

    pll_reconfig_seq_if rif ();

    pll_reconfig_seq #(
        .OFF_CYC  (2),
        .LOCK_CYC (4)
    ) dut (
        .clk_csr    (clk_csr),
        .rst_n      (rst_n),
        .req        (rif),
        .div_fb_o   (div_fb_o),
        .div_out_o  (div_out_o),
        .clk_sel_o  (clk_sel_o),
        .enb_o      (enb_o),
        .busy       (busy),
        .done_pulse (done_pulse),
        .err_pulse  (err_pulse)
    );

    initial clk_csr = 1'b0;
    always #5 clk_csr = ~clk_csr;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk_csr);
            #1;
        end
    endtask

    // Present a request for one edge; returns in cycle 1.
    task automatic send(input logic [1:0] ch, input logic [3:0] fb,
                        input logic [3:0] dout, input logic [1:0] sel);
        rif.req_valid   = 1'b1;
        rif.req_ch      = ch;
        rif.req_div_fb  = fb;
        rif.req_div_out = dout;
        rif.req_sel     = sel;
        tick(1);
        rif.req_valid   = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (!rif.req_ready && n < 300) begin
            tick(1);
            n++;
        end
        if (n >= 300) chk("idle_timeout", 0, 1);
    endtask

    task automatic wait_done(output int l);
        l = 1;
        while (!done_pulse && l < 300) begin
            tick(1);
            l++;
        end
        if (l >= 300) chk("done_timeout", 0, 1);
    endtask

    initial begin
        n_chk = 0;
        n_err = 0;
        rst_n = 1'b0;
        rif.req_valid   = 1'b0;
        rif.req_ch      = '0;
        rif.req_div_fb  = '0;
        rif.req_div_out = '0;
        rif.req_sel     = '0;
        tick(3);
        rst_n = 1'b1;
        tick(1);

        chk("rst_enb", 32'(enb_o), 32'hF);
        chk("rst_fb", 32'(div_fb_o), 32'h1111);
        chk("rst_out", 32'(div_out_o), 32'h1111);
        chk("rst_sel", 32'(clk_sel_o), 32'h0);
        chk("rst_ready", 32'(rif.req_ready), 32'h1);
        chk("rst_busy", 32'(busy), 32'h0);

        // Basic: ch1 fb=5 out=3 from clk.
        send(2'd1, 4'd5, 4'd3, 2'd0);
        chk("b_busy1", 32'(busy), 32'h1);
        chk("b_ready1", 32'(rif.req_ready), 32'h0);
        tick(1);
        chk("b_fb2", 32'(div_fb_o), 32'h1111);
        tick(1);
        chk("b_fb3", 32'(div_fb_o), 32'h1151);
        chk("b_out3", 32'(div_out_o), 32'h1131);
        chk("b_enb3", 32'(enb_o), 32'hF);
        tick(1);
        chk("b_enb4", 32'(enb_o), 32'hD);
        for (int k = 4; k <= 9; k++) begin
            chk($sformatf("b_done%0d", k), 32'(done_pulse),
                (k == 8) ? 32'h1 : 32'h0);
            tick(1);
        end
        chk("b_ready", 32'(rif.req_ready), 32'h1);

        // Setup: ch0 from clk, ch2 sourced from ch0.
        send(2'd0, 4'd2, 4'd2, 2'd0);
        wait_idle();
        send(2'd2, 4'd3, 4'd4, 2'd1);
        wait_idle();
        chk("s_enb", 32'(enb_o), 32'h8);
        chk("s_sel", 32'(clk_sel_o), 32'h10);

        // Reconfigure ch0 with dependent ch2.
        send(2'd0, 4'd6, 4'd7, 2'd0);
        chk("d_enb1", 32'(enb_o), 32'hD);
        tick(2);
        chk("d_enb3", 32'(enb_o), 32'hD);
        tick(1);
        chk("d_enb4", 32'(enb_o), 32'hC);
        tick(3);
        chk("d_enb7", 32'(enb_o), 32'hC);
        chk("d_done7", 32'(done_pulse), 32'h0);
        tick(1);
        chk("d_enb8", 32'(enb_o), 32'h8);
        tick(3);
        chk("d_done11", 32'(done_pulse), 32'h0);
        tick(1);
        chk("d_done12", 32'(done_pulse), 32'h1);
        chk("d_fb", 32'(div_fb_o), 32'h1356);
        chk("d_out", 32'(div_out_o), 32'h1437);
        tick(1);

        // Illegal divider on ch3.
        send(2'd3, 4'd2, 4'd0, 2'd0);
        chk("r_err1", 32'(err_pulse), 32'h1);
        chk("r_done1", 32'(done_pulse), 32'h0);
        chk("r_enb1", 32'(enb_o), 32'h8);
        chk("r_fb1", 32'(div_fb_o), 32'h1356);
        chk("r_out1", 32'(div_out_o), 32'h1437);
        tick(1);
        chk("r_err2", 32'(err_pulse), 32'h0);
        chk("r_ready2", 32'(rif.req_ready), 32'h1);

        // Loop: ch0 selecting ch2 while ch2 sources ch0.
        send(2'd0, 4'd2, 4'd2, 2'd2);
        chk("l_err1", 32'(err_pulse), 32'h1);
        chk("l_sel1", 32'(clk_sel_o), 32'h10);
        tick(1);
        chk("l_ready2", 32'(rif.req_ready), 32'h1);
        chk("l_sel2", 32'(clk_sel_o), 32'h10);

        // Reset while in LOCK_C.
        send(2'd1, 4'd9, 4'd9, 2'd0);
        tick(4);
        #2;
        rst_n = 1'b0;
        #1;
        chk("x_enb", 32'(enb_o), 32'hF);
        chk("x_fb", 32'(div_fb_o), 32'h1111);
        chk("x_out", 32'(div_out_o), 32'h1111);
        chk("x_sel", 32'(clk_sel_o), 32'h0);
        chk("x_busy", 32'(busy), 32'h0);
        chk("x_done", 32'(done_pulse), 32'h0);
        tick(2);
        #2;
        rst_n = 1'b1;
        tick(1);
        chk("x_ready", 32'(rif.req_ready), 32'h1);

        // Fresh request after reset.
        send(2'd1, 4'd5, 4'd3, 2'd0);
        wait_done(lat);
        chk("f_lat", 32'(lat), 32'd8);
        tick(1);
        chk("f_enb", 32'(enb_o), 32'hD);
        chk("f_fb", 32'(div_fb_o), 32'h1151);
        chk("f_ready", 32'(rif.req_ready), 32'h1);

        $display("Simulation finished: %0d checks, %0d errors",
                 n_chk, n_err);
        $finish;
    end

endmodule
